// File: rtl/multi_axis_step_sequencer.sv
// multi_axis_step_sequencer
//
// Coordinated step/dir sequencer for NUM_AXES motor channels. One command
// carries a step count, step period and direction for every axis; all axes
// start together and a single done pulse marks the end of the whole move.
//
// Optional feature: define STEPPER_POSITION_EN to add per-axis signed
// position counters (ports pos/pos_clear and parameter POS_W).
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-high reset
//   en          1 = run, 0 = freeze counters, phases and step levels
//   cmd_valid   command present
//   cmd_ready   high while idle; command taken on cmd_valid & cmd_ready
//   cmd_steps   packed per-axis step counts, axis 0 in the LSBs
//   cmd_period  packed per-axis step periods in clock cycles
//   cmd_dir     per-axis direction
//   abort       cancel the move in progress (no done pulse)
//   step_out    per-axis step pulses
//   dir_out     per-axis registered direction
//   busy        move in progress
//   done        one-cycle pulse when every axis has finished
//   pos         packed signed positions (STEPPER_POSITION_EN only)
//   pos_clear   zero all positions (STEPPER_POSITION_EN only)

module multi_axis_step_sequencer #(
  parameter int NUM_AXES    = 2,
  parameter int STEP_W      = 16,
  parameter int PERIOD_W    = 20,
  parameter int PULSE_WIDTH = 2,
  parameter int DIR_SETUP   = 1
`ifdef STEPPER_POSITION_EN
  ,
  parameter int POS_W       = 24
`endif
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [NUM_AXES*STEP_W-1:0]   cmd_steps,
  input  logic [NUM_AXES*PERIOD_W-1:0] cmd_period,
  input  logic [NUM_AXES-1:0]          cmd_dir,
  input  logic                         abort,
  output logic [NUM_AXES-1:0]          step_out,
  output logic [NUM_AXES-1:0]          dir_out,
  output logic                         busy,
`ifdef STEPPER_POSITION_EN
  output logic [NUM_AXES*POS_W-1:0]    pos,
  input  logic                         pos_clear,
`endif
  output logic                         done
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, FIN} axis_state_t;

  // The low phase must last at least one cycle, so periods are clamped up.
  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(PULSE_WIDTH + 1);
  localparam logic [PERIOD_W-1:0] HIGH_LOAD  = PERIOD_W'(PULSE_WIDTH - 1);
  localparam logic [PERIOD_W-1:0] LOW_OFFSET = PERIOD_W'(PULSE_WIDTH + 1);
  localparam logic [PERIOD_W-1:0] SETUP_LOAD = PERIOD_W'(DIR_SETUP);

  axis_state_t         state          [NUM_AXES];
  axis_state_t         state_next     [NUM_AXES];
  logic [PERIOD_W-1:0] cnt            [NUM_AXES];
  logic [PERIOD_W-1:0] cnt_next       [NUM_AXES];
  logic [STEP_W-1:0]   remaining      [NUM_AXES];
  logic [STEP_W-1:0]   remaining_next [NUM_AXES];
  logic [PERIOD_W-1:0] period_q       [NUM_AXES];
  logic                all_fin_next;
  logic                accept;
  logic                advance;

  assign cmd_ready = ~busy;
  assign accept    = cmd_valid & cmd_ready & ~abort;
  assign advance   = busy & en & ~abort;

  always_comb begin
    for (int i = 0; i < NUM_AXES; i++) begin
      step_out[i] = (state[i] == HIGH);
    end
  end

  // Phase counters count down to zero. SETUP is loaded with DIR_SETUP on the
  // accept edge, so it spans DIR_SETUP+1 register cycles and the first pulse
  // appears DIR_SETUP+1 edges after accept. LOW is loaded with
  // period-PULSE_WIDTH-1 so one full step takes exactly period cycles.
  always_comb begin
    all_fin_next = 1'b1;
    for (int i = 0; i < NUM_AXES; i++) begin
      state_next[i]     = state[i];
      cnt_next[i]       = cnt[i];
      remaining_next[i] = remaining[i];
      unique case (state[i])
        SETUP: begin
          if (cnt[i] == '0) begin
            state_next[i] = HIGH;
            cnt_next[i]   = HIGH_LOAD;
          end else begin
            cnt_next[i] = cnt[i] - 1'b1;
          end
        end
        HIGH: begin
          if (cnt[i] == '0) begin
            state_next[i] = LOW;
            cnt_next[i]   = period_q[i] - LOW_OFFSET;
          end else begin
            cnt_next[i] = cnt[i] - 1'b1;
          end
        end
        LOW: begin
          if (cnt[i] == '0) begin
            if (remaining[i] == STEP_W'(1)) begin
              state_next[i]     = FIN;
              remaining_next[i] = '0;
            end else begin
              state_next[i]     = HIGH;
              remaining_next[i] = remaining[i] - 1'b1;
              cnt_next[i]       = HIGH_LOAD;
            end
          end else begin
            cnt_next[i] = cnt[i] - 1'b1;
          end
        end
        default: begin
        end
      endcase
      if (state_next[i] != FIN) all_fin_next = 1'b0;
    end
  end

  // Priority: reset, abort, accept, then normal advance. The edge on which
  // every axis would reach FIN raises done and returns straight to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_AXES; i++) begin
        state[i]     <= IDLE;
        cnt[i]       <= '0;
        remaining[i] <= '0;
        period_q[i]  <= '0;
      end
      dir_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        for (int i = 0; i < NUM_AXES; i++) state[i] <= IDLE;
        busy <= 1'b0;
      end else if (accept) begin
        busy    <= 1'b1;
        dir_out <= cmd_dir;
        for (int i = 0; i < NUM_AXES; i++) begin
          remaining[i] <= cmd_steps[i*STEP_W +: STEP_W];
          period_q[i]  <= (cmd_period[i*PERIOD_W +: PERIOD_W] < MIN_PERIOD)
                          ? MIN_PERIOD : cmd_period[i*PERIOD_W +: PERIOD_W];
          cnt[i]       <= SETUP_LOAD;
          state[i]     <= (cmd_steps[i*STEP_W +: STEP_W] == '0) ? FIN : SETUP;
        end
      end else if (advance) begin
        if (all_fin_next) begin
          for (int i = 0; i < NUM_AXES; i++) state[i] <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          for (int i = 0; i < NUM_AXES; i++) begin
            state[i]     <= state_next[i];
            cnt[i]       <= cnt_next[i];
            remaining[i] <= remaining_next[i];
          end
        end
      end
    end
  end

`ifdef STEPPER_POSITION_EN
  // A step is counted on the same edge its pulse rises; pos_clear wins over
  // a coinciding step, and abort leaves positions untouched.
  always_ff @(posedge clock) begin
    if (reset || pos_clear) begin
      pos <= '0;
    end else if (advance && !all_fin_next) begin
      for (int i = 0; i < NUM_AXES; i++) begin
        if (state_next[i] == HIGH && state[i] != HIGH) begin
          pos[i*POS_W +: POS_W] <= dir_out[i] ? pos[i*POS_W +: POS_W] + POS_W'(1)
                                              : pos[i*POS_W +: POS_W] - POS_W'(1);
        end
      end
    end
  end
`endif

endmodule
